// File: rtl/adc_att_pkg.sv
// Shared types and defaults for the ADC attenuator controller.
package adc_att_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2,
        DECAY  = 2'd3
    } att_state_t;

    localparam int ATT_W_DEF       = 5;
    localparam int ATT_MAX_DEF     = 31;
    localparam int STEP_UP_DEF     = 3;
    localparam int SETTLE_CLKS_DEF = 256;
    localparam int HOLD_CLKS_DEF   = 40000;
    localparam int DECAY_CLKS_DEF  = 8000;

    // Width needed to hold the longest timer reload value (count - 1).
    function automatic int tmr_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    localparam int TMR_W = tmr_width(SETTLE_CLKS_DEF, HOLD_CLKS_DEF, DECAY_CLKS_DEF);

endpackage

// File: rtl/att_timer.sv
// Loadable down-counter shared by all controller states; holds at zero.
module att_timer #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= value;
        else if (count != '0)
            count <= count - W'(1);
    end

    assign zero = (count == '0);

endmodule

// File: rtl/cdc_sync.sv
// Two-flop synchroniser for asynchronous level inputs.
module cdc_sync #(
    parameter int W = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/adc_att_ctrl.sv
// ADC front-end attenuator controller: steps att up on overrange, holds, then decays to manual_att.
// Optional clip LED stretcher is built when ADC_ATT_CLIP_LED_EN is defined.
module adc_att_ctrl
    import adc_att_pkg::*;
#(
    parameter int ATT_W       = ATT_W_DEF,
    parameter int ATT_MAX     = ATT_MAX_DEF,
    parameter int STEP_UP     = STEP_UP_DEF,
    parameter int SETTLE_CLKS = SETTLE_CLKS_DEF,
    parameter int HOLD_CLKS   = HOLD_CLKS_DEF,
    parameter int DECAY_CLKS  = DECAY_CLKS_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             adc_overrange,
    input  logic             auto_en,
    input  logic [ATT_W-1:0] manual_att,
    output logic [ATT_W-1:0] att,
    output logic             att_stb,
    output logic             auto_active,
    output logic             led_red
);

    localparam int TW = tmr_width(SETTLE_CLKS, HOLD_CLKS, DECAY_CLKS);
    localparam logic [TW-1:0]  SETTLE_LD = TW'(SETTLE_CLKS - 1);
    localparam logic [TW-1:0]  HOLD_LD   = TW'(HOLD_CLKS - 1);
    localparam logic [TW-1:0]  DECAY_LD  = TW'(DECAY_CLKS - 1);
    localparam logic [ATT_W:0] ATT_MAX_X = (ATT_W + 1)'(ATT_MAX);
    localparam logic [ATT_W:0] STEP_X    = (ATT_W + 1)'(STEP_UP);

    att_state_t       state, state_nxt;
    logic [ATT_W-1:0] att_nxt, att_sat, att_dec;
    logic [ATT_W:0]   att_up;
    logic             ovf, tmr_zero, tmr_load, do_step;
    logic             decay_run, decay_run_nxt;
    logic [TW-1:0]    tmr_val;

    cdc_sync #(.W(1)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (adc_overrange),
        .q     (ovf)
    );

    att_timer #(.W(TW)) u_timer (
        .clock (clock),
        .reset (reset),
        .load  (tmr_load),
        .value (tmr_val),
        .zero  (tmr_zero)
    );

    // Step-up is done one bit wider so the clamp sees the true sum.
    assign att_up  = {1'b0, att} + STEP_X;
    assign att_sat = (att_up > ATT_MAX_X) ? ATT_MAX_X[ATT_W-1:0] : att_up[ATT_W-1:0];
    assign att_dec = att - ATT_W'(1);

    // decay_run marks a SETTLE entered from a decay step: it returns to DECAY
    // rather than sitting through another full HOLD period.
    always_comb begin
        state_nxt     = state;
        att_nxt       = att;
        decay_run_nxt = decay_run;
        tmr_load      = 1'b0;
        tmr_val       = '0;
        do_step       = 1'b0;
        if (!auto_en) begin
            state_nxt = IDLE;
            att_nxt   = manual_att;
            tmr_load  = 1'b1;
        end else if (manual_att > att) begin
            state_nxt = IDLE;
            att_nxt   = manual_att;
            tmr_load  = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (ovf) do_step = 1'b1;
                    else     att_nxt = manual_att;
                end
                SETTLE: begin
                    if (tmr_zero) begin
                        tmr_load  = 1'b1;
                        state_nxt = decay_run ? DECAY : HOLD;
                        tmr_val   = decay_run ? DECAY_LD : HOLD_LD;
                    end
                end
                HOLD: begin
                    if (ovf) begin
                        do_step = 1'b1;
                    end else if (tmr_zero) begin
                        state_nxt = DECAY;
                        tmr_load  = 1'b1;
                        tmr_val   = DECAY_LD;
                    end
                end
                DECAY: begin
                    if (ovf) begin
                        do_step = 1'b1;
                    end else if (tmr_zero) begin
                        if (att > manual_att && att_dec != manual_att) begin
                            att_nxt       = att_dec;
                            state_nxt     = SETTLE;
                            decay_run_nxt = 1'b1;
                            tmr_load      = 1'b1;
                            tmr_val       = SETTLE_LD;
                        end else begin
                            if (att > manual_att) att_nxt = att_dec;
                            state_nxt = IDLE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
            if (do_step) begin
                att_nxt       = att_sat;
                state_nxt     = SETTLE;
                decay_run_nxt = 1'b0;
                tmr_load      = 1'b1;
                tmr_val       = SETTLE_LD;
            end
        end
    end

    // att_stb is high for the first cycle a new att value is visible.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            att         <= '0;
            att_stb     <= 1'b0;
            auto_active <= 1'b0;
            decay_run   <= 1'b0;
        end else begin
            state       <= state_nxt;
            att         <= att_nxt;
            att_stb     <= (att_nxt != att);
            auto_active <= auto_en && (att_nxt > manual_att);
            decay_run   <= decay_run_nxt;
        end
    end

`ifdef ADC_ATT_CLIP_LED_EN
    logic [TW-1:0] led_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            led_cnt <= '0;
            led_red <= 1'b0;
        end else if (ovf) begin
            led_cnt <= HOLD_LD;
            led_red <= 1'b1;
        end else if (led_cnt != '0) begin
            led_cnt <= led_cnt - TW'(1);
            led_red <= 1'b1;
        end else begin
            led_red <= 1'b0;
        end
    end
`else
    assign led_red = 1'b0;
`endif

endmodule
